// File: rtl/clk_en_divider.sv
//-----------------------------------------------------------------------------
// clk_en_divider
//
// Multi-channel, run-time programmable clock-enable generator. Every channel
// divides the system clock by its own divisor and produces a one-cycle enable
// tick and a 50%-duty square wave. Both outputs are registered and stay in the
// clk domain, so downstream logic never needs a derived clock.
//
// Each channel has two divisor registers. The active divisor is what the
// counter compares against. The shadow divisor holds a deferred write until
// the next wrap, which lets a divisor change without producing a runt period.
//
// Ports
//   clk     in   1      system clock, all logic on the rising edge
//   reset   in   1      asynchronous, active-high, clears all state
//   en      in   1      global count enable shared by every channel
//   wr      in   1      divisor write strobe, one cycle wide
//   wr_ch   in   SEL_W  channel addressed by the write (out-of-range ignored)
//   wr_div  in   CNT_W  divisor value to write
//   wr_now  in   1      1: load now and restart, 0: load at the next wrap
//   tick    out  NCH    one-cycle pulse per divided period, per channel
//   sq      out  NCH    square wave toggling on every tick, per channel
//   pend    out  NCH    a deferred divisor is waiting for its wrap
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module clk_en_divider #(
  parameter int          NCH      = 4,
  parameter int          CNT_W    = 26,
  parameter int unsigned DIV_INIT = 25_000_000,
  localparam int         SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [SEL_W-1:0] wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_now,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq,
  output logic [NCH-1:0]   pend
);

  // Reset divisor, cast once to the counter width.
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);

  logic wr_valid;

  // A write whose channel number has no matching channel is dropped. This
  // can happen when NCH is not a power of two. Every per-channel decode is
  // gated by this flag, so a bad address can never alias onto a real channel.
  assign wr_valid = wr && (32'(wr_ch) < 32'(NCH));

  for (genvar g = 0; g < NCH; g++) begin : g_ch

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] next_div;
    logic             hit;
    logic             stopped;
    logic             wrap;
    logic             tick_q;
    logic             sq_q;
    logic             pend_q;

    // Per-channel decode terms.
    // The wrap compare is done in CNT_W bits against div-1. Because cnt is
    // cleared on every wrap and on every divisor load, cnt can never pass
    // div-1, so the counter has no overflow path. The "stopped" case (div=0)
    // is handled before wrap is used, so the underflow of div-1 is harmless.
    // Whenever nothing is pending, shadow equals div. That lets next_div
    // always read from shadow, unless a write lands on this same wrap edge;
    // in that case the fresh value wins.
    assign hit      = wr_valid && (wr_ch == SEL_W'(g));
    assign stopped  = (div == '0);
    assign wrap     = (cnt == div - CNT_W'(1));
    assign next_div = hit ? wr_div : shadow;

    // Channel state machine, evaluated in priority order:
    //  1. Immediate write: load both divisors, restart the count and clear
    //     the outputs, whatever the state of en.
    //  2. Stopped channel (div=0): hold everything at zero. A deferred write
    //     has no wrap to wait for, so it loads straight away.
    //  3. Global enable low: freeze the count and square wave and suppress
    //     ticks. Writes still land in the shadow and stay pending.
    //  4. Wrap: tick, toggle the square wave and adopt the shadow divisor.
    //     The new period starts on this edge. If the new divisor is zero, the
    //     square wave is parked low so a stopped channel always reads sq=0.
    //  5. Otherwise count up. A write here is deferred to the next wrap.
    //     Repeated deferred writes simply overwrite the shadow.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt    <= '0;
        div    <= DIV_RST;
        shadow <= DIV_RST;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        pend_q <= 1'b0;
      end else if (hit && wr_now) begin
        cnt    <= '0;
        div    <= wr_div;
        shadow <= wr_div;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        pend_q <= 1'b0;
      end else if (stopped) begin
        cnt    <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        if (hit) begin
          div    <= wr_div;
          shadow <= wr_div;
          pend_q <= 1'b0;
        end
      end else if (!en) begin
        tick_q <= 1'b0;
        if (hit) begin
          shadow <= wr_div;
          pend_q <= 1'b1;
        end
      end else if (wrap) begin
        cnt    <= '0;
        div    <= next_div;
        shadow <= next_div;
        tick_q <= 1'b1;
        sq_q   <= (next_div == '0) ? 1'b0 : ~sq_q;
        pend_q <= 1'b0;
      end else begin
        cnt    <= cnt + CNT_W'(1);
        tick_q <= 1'b0;
        if (hit) begin
          shadow <= wr_div;
          pend_q <= 1'b1;
        end
      end
    end

    assign tick[g] = tick_q;
    assign sq[g]   = sq_q;
    assign pend[g] = pend_q;

  end

endmodule

// File: tb/tb_clk_en_divider.sv
//-----------------------------------------------------------------------------
// tb_clk_en_divider
//
// Directed bench for clk_en_divider with NCH=3, CNT_W=8, DIV_INIT=5.
// The first 30 edges after reset come from a hand-computed vector table:
// free-running divide-by-5, then a deferred write of 3 to channel 1.
// Hand-written sequences cover the remaining corners:
//   - immediate reload
//   - div=0 and div=1
//   - pausing en while a write is pending
//   - writes to an out-of-range channel
//   - asynchronous reset in the middle of a count
// All outputs are sampled 1 ns after the rising edge.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clk_en_divider;

  localparam int NCH      = 3;
  localparam int CNT_W    = 8;
  localparam int DIV_INIT = 5;
  localparam int NVEC     = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       wr;
  logic [1:0] wr_ch;
  logic [7:0] wr_div;
  logic       wr_now;
  logic [2:0] tick;
  logic [2:0] sq;
  logic [2:0] pend;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       wr;
    logic [1:0] ch;
    logic [7:0] dv;
    logic       now;
    logic [2:0] t;
    logic [2:0] s;
    logic [2:0] p;
  } vec_t;

  vec_t vecs [NVEC];

  clk_en_divider #(
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .DIV_INIT (DIV_INIT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .wr     (wr),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .wr_now (wr_now),
    .tick   (tick),
    .sq     (sq),
    .pend   (pend)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends, even if the clock were to stall.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic e, input logic w, input logic [1:0] c,
                                 input logic [7:0] d, input logic n,
                                 input logic [2:0] t, input logic [2:0] s,
                                 input logic [2:0] p);
    vec_t v;
    v.en = e; v.wr = w; v.ch = c; v.dv = d; v.now = n;
    v.t = t; v.s = s; v.p = p;
    return v;
  endfunction

  // Drive one cycle of inputs, take the rising edge, land 1 ns after it.
  task automatic applyStimulus(input logic e, input logic w, input logic [1:0] c,
                               input logic [7:0] d, input logic n);
    en     = e;
    wr     = w;
    wr_ch  = c;
    wr_div = d;
    wr_now = n;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    wr     = 1'b0;
    wr_ch  = 2'd0;
    wr_div = 8'd0;
    wr_now = 1'b0;

    // Edges 1..30 after reset release. Bit i of t/s/p is channel i.
    vecs[0]  = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[1]  = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[2]  = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[3]  = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[4]  = mkVec(1, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000);
    vecs[5]  = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    vecs[6]  = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    vecs[7]  = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    vecs[8]  = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    vecs[9]  = mkVec(1, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    vecs[10] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[11] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[12] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[13] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[14] = mkVec(1, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000);
    vecs[15] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    // Channel 1 sits at cnt=1 here; defer a divisor of 3.
    vecs[16] = mkVec(1, 1, 1, 3, 0, 3'b000, 3'b111, 3'b010);
    vecs[17] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b010);
    vecs[18] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b010);
    vecs[19] = mkVec(1, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    vecs[20] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[21] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    vecs[22] = mkVec(1, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000);
    vecs[23] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000);
    vecs[24] = mkVec(1, 0, 0, 0, 0, 3'b101, 3'b111, 3'b000);
    vecs[25] = mkVec(1, 0, 0, 0, 0, 3'b010, 3'b101, 3'b000);
    vecs[26] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b101, 3'b000);
    vecs[27] = mkVec(1, 0, 0, 0, 0, 3'b000, 3'b101, 3'b000);
    vecs[28] = mkVec(1, 0, 0, 0, 0, 3'b010, 3'b111, 3'b000);
    vecs[29] = mkVec(1, 0, 0, 0, 0, 3'b101, 3'b010, 3'b000);

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tick", tick, 3'b000);
    checkOutput("rst_sq",   sq,   3'b000);
    checkOutput("rst_pend", pend, 3'b000);

    // Release 1 ns after an edge so the next edge is edge 1.
    en    = 1'b1;
    reset = 1'b0;

    $display("[TB] vector table, edges 1..%0d", NVEC);
    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vecs[k].en, vecs[k].wr, vecs[k].ch, vecs[k].dv, vecs[k].now);
      checkOutput($sformatf("tick@%0d", k + 1), tick, vecs[k].t);
      checkOutput($sformatf("sq@%0d",   k + 1), sq,   vecs[k].s);
      checkOutput($sformatf("pend@%0d", k + 1), pend, vecs[k].p);
    end

    // Edge 31: immediate reload of channel 2 with 2.
    $display("[TB] immediate write ch2 div=2");
    applyStimulus(1, 1, 2, 8'd2, 1);
    checkOutput("now_tick@31", tick, 3'b000);
    checkOutput("now_sq2@31", {2'b00, sq[2]}, 3'b000);
    // Edges 32..37: ch2 every 2 edges, ch1 at 32/35, ch0 at 35.
    for (int j = 1; j <= 6; j++) begin
      logic [2:0] et;
      logic       es2;
      applyStimulus(1, 0, 0, 8'd0, 0);
      et[0] = (j == 4);
      et[1] = (j == 1) || (j == 4);
      et[2] = (j % 2 == 0);
      es2   = ((j / 2) % 2) == 1;
      checkOutput($sformatf("div2_tick@%0d", 31 + j), tick, et);
      checkOutput($sformatf("div2_sq2@%0d", 31 + j), {2'b00, sq[2]}, {2'b00, es2});
    end

    // Edge 38: stop channel 0 (its sq was high since edge 35).
    $display("[TB] ch0 div=0 then div=1");
    applyStimulus(1, 1, 0, 8'd0, 1);
    checkOutput("stop_tick0@38", {2'b00, tick[0]}, 3'b000);
    checkOutput("stop_sq0@38",   {2'b00, sq[0]},   3'b000);
    for (int j = 39; j <= 40; j++) begin
      applyStimulus(1, 0, 0, 8'd0, 0);
      checkOutput($sformatf("stop_tick0@%0d", j), {2'b00, tick[0]}, 3'b000);
      checkOutput($sformatf("stop_sq0@%0d", j),   {2'b00, sq[0]},   3'b000);
    end
    // Edge 41: a deferred write on a stopped channel loads at once.
    applyStimulus(1, 1, 0, 8'd1, 0);
    checkOutput("div1_load_tick0@41", {2'b00, tick[0]}, 3'b000);
    checkOutput("div1_load_pend@41",  pend, 3'b000);
    for (int j = 0; j < 6; j++) begin
      applyStimulus(1, 0, 0, 8'd0, 0);
      checkOutput($sformatf("div1_tick0@%0d", 42 + j), {2'b00, tick[0]}, 3'b001);
      checkOutput($sformatf("div1_sq0@%0d", 42 + j), {2'b00, sq[0]}, {2'b00, (j % 2 == 0)});
    end

    // Edges 48..61: channel 2 restarted with 6. A deferred 4 is written at
    // cnt=2, then en drops for 3 edges. The wrap moves from 54 to 57.
    $display("[TB] en pause with pending write on ch2");
    applyStimulus(1, 1, 2, 8'd6, 1);
    for (int j = 49; j <= 50; j++) begin
      applyStimulus(1, 0, 0, 8'd0, 0);
      checkOutput($sformatf("pause_tick2@%0d", j), {2'b00, tick[2]}, 3'b000);
    end
    applyStimulus(1, 1, 2, 8'd4, 0);
    checkOutput("pause_pend@51", pend, 3'b100);
    for (int j = 52; j <= 54; j++) begin
      applyStimulus(0, 0, 0, 8'd0, 0);
      checkOutput($sformatf("pause_tick@%0d", j), tick, 3'b000);
      checkOutput($sformatf("pause_sq2@%0d", j), {2'b00, sq[2]}, 3'b000);
      checkOutput($sformatf("pause_pend@%0d", j), pend, 3'b100);
    end
    for (int j = 55; j <= 56; j++) begin
      applyStimulus(1, 0, 0, 8'd0, 0);
      checkOutput($sformatf("resume_tick2@%0d", j), {2'b00, tick[2]}, 3'b000);
      checkOutput($sformatf("resume_pend@%0d", j), pend, 3'b100);
    end
    applyStimulus(1, 0, 0, 8'd0, 0);
    checkOutput("wrap_tick2@57", {2'b00, tick[2]}, 3'b001);
    checkOutput("wrap_sq2@57",   {2'b00, sq[2]},   3'b001);
    checkOutput("wrap_pend@57",  pend, 3'b000);
    for (int j = 58; j <= 60; j++) begin
      applyStimulus(1, 0, 0, 8'd0, 0);
      checkOutput($sformatf("div4_tick2@%0d", j), {2'b00, tick[2]}, 3'b000);
    end
    applyStimulus(1, 0, 0, 8'd0, 0);
    checkOutput("div4_tick2@61", {2'b00, tick[2]}, 3'b001);
    checkOutput("div4_sq2@61",   {2'b00, sq[2]},   3'b000);

    // Edge 62: a write to nonexistent channel 3 must not touch any channel.
    $display("[TB] out-of-range channel write");
    applyStimulus(1, 1, 3, 8'd0, 1);
    checkOutput("badch_tick@62", tick, 3'b011);
    checkOutput("badch_pend@62", pend, 3'b000);
    applyStimulus(1, 0, 0, 8'd0, 0);
    checkOutput("badch_tick@63", tick, 3'b001);
    applyStimulus(1, 0, 0, 8'd0, 0);
    checkOutput("badch_tick@64", tick, 3'b001);
    applyStimulus(1, 0, 0, 8'd0, 0);
    checkOutput("badch_tick@65", tick, 3'b111);

    // Edge 66: leave a deferred write pending, then reset between edges.
    $display("[TB] async reset mid-count");
    applyStimulus(1, 1, 1, 8'd7, 0);
    checkOutput("prerst_pend@66", pend, 3'b010);
    checkOutput("prerst_tick@66", tick, 3'b001);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_tick", tick, 3'b000);
    checkOutput("async_rst_sq",   sq,   3'b000);
    checkOutput("async_rst_pend", pend, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    // Pending divisor 7 is lost: every channel runs at the reset divisor 5.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1, 0, 0, 8'd0, 0);
      checkOutput($sformatf("post_rst_tick@%0d", k), tick, (k % 5 == 0) ? 3'b111 : 3'b000);
    end
    checkOutput("post_rst_pend", pend, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
